// File: rtl/iso_stream_mux_if.sv
// rtl/iso_stream_mux_if.sv - source/select inputs and selected-stream outputs of iso_stream_mux
interface iso_stream_mux_if #(
    parameter int LANES   = 4,
    parameter int SYM_W   = 8,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC*LANES*SYM_W-1:0] src_symbols;
    logic [NUM_SRC*LANES-1:0]       src_ctrl_flags;
    logic [SEL_W-1:0]               sel;
    logic                           sel_valid;
    logic                           err_clr;
    logic                           cnt_clr;
    logic [LANES*SYM_W-1:0]         out_symbols;
    logic [LANES-1:0]               out_ctrl_flags;
    logic [SEL_W-1:0]               out_src;
    logic                           sw_pulse;
    logic                           sel_err;
    logic [15:0]                    switch_cnt;

    modport master (
        output src_symbols, src_ctrl_flags, sel, sel_valid, err_clr, cnt_clr,
        input  out_symbols, out_ctrl_flags, out_src, sw_pulse, sel_err, switch_cnt
    );

    modport slave (
        input  src_symbols, src_ctrl_flags, sel, sel_valid, err_clr, cnt_clr,
        output out_symbols, out_ctrl_flags, out_src, sw_pulse, sel_err, switch_cnt
    );
endinterface

// File: rtl/iso_stream_mux.sv
// rtl/iso_stream_mux.sv - pipelined multi-lane source selector with switch reporting
module iso_stream_mux #(
    parameter int LANES   = 4,
    parameter int SYM_W   = 8,
    parameter int NUM_SRC = 3,
    parameter int DEF_SRC = 0,
    parameter int PIPE    = 1,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    iso_stream_mux_if.slave io_bus
);
    localparam int              DW      = LANES * SYM_W;
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEF_SRC);

    logic [SEL_W-1:0] r_act_sel;
    logic [SEL_W-1:0] w_eff_sel;
    logic [SEL_W-1:0] w_last_tag_in;
    logic [DW-1:0]    w_sym;
    logic [LANES-1:0] w_flg;

    logic [DW-1:0]    r_sym [PIPE];
    logic [LANES-1:0] r_flg [PIPE];
    logic [SEL_W-1:0] r_tag [PIPE];
    logic             r_sw_pulse;
    logic             r_sel_err;
    logic [15:0]      r_switch_cnt;

    // A new select takes effect on the data sampled in the same cycle.
    always_comb begin
        w_eff_sel = r_act_sel;
        if (io_bus.sel_valid) begin
            w_eff_sel = (int'(io_bus.sel) < NUM_SRC) ? io_bus.sel : DEF_SEL;
        end
        w_sym = io_bus.src_symbols[DEF_SRC*DW +: DW];
        w_flg = io_bus.src_ctrl_flags[DEF_SRC*LANES +: LANES];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_eff_sel == SEL_W'(k)) begin
                w_sym = io_bus.src_symbols[k*DW +: DW];
                w_flg = io_bus.src_ctrl_flags[k*LANES +: LANES];
            end
        end
    end

    generate
        if (PIPE == 1) begin : g_tag_single
            assign w_last_tag_in = w_eff_sel;
        end else begin : g_tag_multi
            assign w_last_tag_in = r_tag[PIPE-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_sel <= DEF_SEL;
            for (int i = 0; i < PIPE; i++) begin
                r_sym[i] <= '0;
                r_flg[i] <= '0;
                r_tag[i] <= DEF_SEL;
            end
        end else begin
            if (io_bus.sel_valid) begin
                r_act_sel <= w_eff_sel;
            end
            r_sym[0] <= w_sym;
            r_flg[0] <= w_flg;
            r_tag[0] <= w_eff_sel;
            for (int i = 1; i < PIPE; i++) begin
                r_sym[i] <= r_sym[i-1];
                r_flg[i] <= r_flg[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Switch pulse, sticky error and saturating switch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_pulse   <= 1'b0;
            r_sel_err    <= 1'b0;
            r_switch_cnt <= '0;
        end else begin
            r_sw_pulse <= (w_last_tag_in != r_tag[PIPE-1]);
            if (io_bus.sel_valid && (int'(io_bus.sel) >= NUM_SRC)) begin
                r_sel_err <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_sel_err <= 1'b0;
            end
            if (io_bus.cnt_clr) begin
                r_switch_cnt <= '0;
            end else if (r_sw_pulse && (r_switch_cnt != 16'hFFFF)) begin
                r_switch_cnt <= r_switch_cnt + 16'd1;
            end
        end
    end

    assign io_bus.out_symbols    = r_sym[PIPE-1];
    assign io_bus.out_ctrl_flags = r_flg[PIPE-1];
    assign io_bus.out_src        = r_tag[PIPE-1];
    assign io_bus.sw_pulse       = r_sw_pulse;
    assign io_bus.sel_err        = r_sel_err;
    assign io_bus.switch_cnt     = r_switch_cnt;
endmodule

// File: tb/tb_iso_stream_mux.sv
// tb/tb_iso_stream_mux.sv - scoreboard bench for iso_stream_mux (LANES=4, NUM_SRC=3, PIPE=2)
module tb_iso_stream_mux;
    localparam int LANES   = 4;
    localparam int SYM_W   = 8;
    localparam int NUM_SRC = 3;
    localparam int PIPE    = 2;
    localparam int SEL_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iso_stream_mux_if #(.LANES(LANES), .SYM_W(SYM_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    iso_stream_mux #(
        .LANES(LANES), .SYM_W(SYM_W), .NUM_SRC(NUM_SRC),
        .DEF_SRC(0), .PIPE(PIPE), .SEL_W(SEL_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [31:0] sym;
        logic [3:0]  flg;
        logic [1:0]  src;
        logic        sw;
    } exp_t;

    exp_t sb[$];
    logic [31:0] sym_tab [3] = '{32'h1C1C1C1C, 32'hB3B2B1B0, 32'hA3A2A1A0};
    logic [3:0]  flg_tab [3] = '{4'b1111, 4'b0101, 4'b0010};

    int          n_vec   = 0;
    int          n_err   = 0;
    bit          running = 1'b0;
    logic [1:0]  m_act;
    logic [1:0]  m_prev;
    logic [15:0] exp_cnt;
    logic        exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_push();
        logic [1:0] eff;
        exp_t       e;
        eff = bus.sel_valid ? ((bus.sel < 2'd3) ? bus.sel : 2'd0) : m_act;
        if (bus.sel_valid) m_act = eff;
        e.sym = sym_tab[eff];
        e.flg = flg_tab[eff];
        e.src = eff;
        e.sw  = (eff != m_prev);
        m_prev = eff;
        sb.push_back(e);
    endfunction

    task automatic cycle(input logic v, input logic [1:0] s, input logic ec, input logic cc);
        @(posedge clk);
        #1;
        bus.sel_valid = v;
        bus.sel       = s;
        bus.err_clr   = ec;
        bus.cnt_clr   = cc;
        model_push();
    endtask

    task automatic do_reset();
        exp_t r;
        @(posedge clk);
        #1;
        running       = 1'b0;
        rst_n         = 1'b0;
        bus.sel_valid = 1'b0;
        bus.sel       = 2'd0;
        bus.err_clr   = 1'b0;
        bus.cnt_clr   = 1'b0;
        #1;
        chk("rst_out_symbols", bus.out_symbols, 32'h0);
        chk("rst_out_ctrl_flags", 32'(bus.out_ctrl_flags), 32'h0);
        chk("rst_out_src", 32'(bus.out_src), 32'h0);
        chk("rst_sw_pulse", 32'(bus.sw_pulse), 32'h0);
        chk("rst_sel_err", 32'(bus.sel_err), 32'h0);
        chk("rst_switch_cnt", 32'(bus.switch_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        r = '{sym: 32'h0, flg: 4'h0, src: 2'd0, sw: 1'b0};
        for (int i = 0; i < PIPE; i++) sb.push_back(r);
        m_act   = 2'd0;
        m_prev  = 2'd0;
        exp_cnt = 16'h0;
        exp_err = 1'b0;
        model_push();
        running = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (running) begin
            e = '0;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("out_symbols", bus.out_symbols, e.sym);
                chk("out_ctrl_flags", 32'(bus.out_ctrl_flags), 32'(e.flg));
                chk("out_src", 32'(bus.out_src), 32'(e.src));
                chk("sw_pulse", 32'(bus.sw_pulse), 32'(e.sw));
            end
            chk("sel_err", 32'(bus.sel_err), 32'(exp_err));
            chk("switch_cnt", 32'(bus.switch_cnt), 32'(exp_cnt));
            if (bus.cnt_clr) exp_cnt = 16'h0;
            else if (e.sw && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (bus.sel_valid && bus.sel >= 2'd3) exp_err = 1'b1;
            else if (bus.err_clr) exp_err = 1'b0;
        end
    end

    initial begin
        bus.src_symbols    = {8'hA3, 8'hA2, 8'hA1, 8'hA0,
                              8'hB3, 8'hB2, 8'hB1, 8'hB0,
                              8'h1C, 8'h1C, 8'h1C, 8'h1C};
        bus.src_ctrl_flags = {4'b0010, 4'b0101, 4'b1111};
        bus.sel_valid = 1'b0;
        bus.sel       = 2'd0;
        bus.err_clr   = 1'b0;
        bus.cnt_clr   = 1'b0;

        do_reset();
        repeat (9) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_active_src", 32'(bus.out_src), 32'd2);
        chk("hold_active_cnt", 32'(bus.switch_cnt), 32'd1);

        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("illegal_fallback_src", 32'(bus.out_src), 32'd0);
        chk("illegal_sticky_err", 32'(bus.sel_err), 32'd1);
        cycle(1'b1, 2'd3, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_set_wins", 32'(bus.sel_err), 32'd1);
        cycle(1'b0, 2'd0, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("err_cleared", 32'(bus.sel_err), 32'd0);

        for (int i = 0; i < 10; i++) cycle(1'b1, (i % 2) ? 2'd2 : 2'd1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 2'd0, 1'b0, 1'b0);

        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) cycle(1'b1, (i % 2) ? 2'd2 : 2'd1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_saturated", 32'(bus.switch_cnt), 32'h0000FFFF);
        cycle(1'b1, 2'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("cnt_clr_over_pulse", 32'(bus.switch_cnt), 32'h0);

        cycle(1'b1, 2'd3, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, 1'b0, 1'b0);
        do_reset();
        repeat (6) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iso_stream_mux.md
# iso_stream_mux

Parametrised, pipelined source multiplexer for the ISO transport path. It selects one of NUM_SRC symbol sources (active video, blanking, idle, and any future fill sources) across LANES lanes, carrying each symbol's control-symbol flag alongside it. The selection is held between scheduler updates, and illegal selects fall back to a safe default source. The block also reports source switches, aligned with the output data, to the downstream lane framer.

## Interface
Parameters:
- LANES, 4, number of parallel lanes (1..4)
- SYM_W, 8, symbol width in bits
- NUM_SRC, 3, number of input sources (2..8)
- DEF_SRC, 0, source index used after reset and on illegal select (idle source)
- PIPE, 1, output pipeline depth in cycles (1..3)
- SEL_W, $clog2(NUM_SRC) with a minimum of 1, derived select width

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_symbols  in  NUM_SRC*LANES*SYM_W  source k at [k*LANES*SYM_W +: LANES*SYM_W]; lane 0 in LSBs
- src_ctrl_flags  in  NUM_SRC*LANES  source k at [k*LANES +: LANES]; lane 0 in LSB
- sel  in  SEL_W  requested source index
- sel_valid  in  1  sel is applied this cycle
- err_clr  in  1  clear sel_err
- cnt_clr  in  1  clear switch_cnt
- out_symbols  out  LANES*SYM_W  selected symbols
- out_ctrl_flags  out  LANES  selected control flags
- out_src  out  SEL_W  index of the source currently on out_symbols
- sw_pulse  out  1  first cycle of a new source at the output
- sel_err  out  1  sticky illegal-select flag
- switch_cnt  out  16  saturating count of sw_pulse events

## Operation
- Held selection register act_sel. Reset value: DEF_SRC.
- Effective select for the current cycle:
  - sel_valid=1 and sel<NUM_SRC: eff_sel = sel.
  - sel_valid=1 and sel>=NUM_SRC: eff_sel = DEF_SRC.
  - sel_valid=0: eff_sel = act_sel.
- act_sel loads eff_sel on every edge where sel_valid=1. Otherwise it holds. With sel_valid=0 the previous source persists indefinitely.
- Stage 1 registers the source eff_sel: all LANES symbols and flags, plus the tag eff_sel. Stages 2..PIPE shift symbols, flags and tag unchanged. The last stage drives out_symbols, out_ctrl_flags and out_src.
- sw_pulse is registered. It is high for one cycle when the out_src value entering the last stage differs from the current out_src. It is therefore high in the first cycle a new source is visible.
- Reselecting the current source (sel_valid=1 with sel equal to act_sel) does not produce sw_pulse.
- sel_err is set on an edge where sel_valid=1 and sel>=NUM_SRC. It is cleared by err_clr. If set and clear coincide, set wins.
- switch_cnt increments on an edge where sw_pulse=1. It saturates at 16'hFFFF. cnt_clr forces it to 0 and takes priority over increment.
- No lane reordering and no symbol modification: the block is a pure selection and delay.

## Timing
- Reset (asynchronous assert, release synchronised externally) gives:
  - out_symbols=0, out_ctrl_flags=0
  - out_src=DEF_SRC and all pipeline tags=DEF_SRC
  - sw_pulse=0, sel_err=0, switch_cnt=0, act_sel=DEF_SRC
- Latency: data presented in cycle t under eff_sel appears on the outputs in cycle t+PIPE. out_src is aligned with the data.
- A sel_valid in cycle t affects the data sampled in cycle t, not t+1.
- Back-to-back sel_valid on consecutive cycles is legal. Each cycle's data follows that cycle's sel.
- Alternating sources every cycle gives sw_pulse high continuously, and switch_cnt adds 1 per cycle.
- Reset asserted mid-stream: all pipeline contents are discarded at once. The first data after release is sampled with act_sel=DEF_SRC unless sel_valid is high in that cycle.
- After reset, the first DEF_SRC data reaching the output produces no sw_pulse.

## Test plan
- Reset, then hold sel_valid=0 with idle source (index 0) lane bytes 0x1C on all lanes, LANES=4, PIPE=1. Required: out_symbols=0x1C1C1C1C from cycle 1, sw_pulse never asserts, switch_cnt=0.
- With PIPE=2: sel_valid=1 with sel=2 (active, lanes 0xA0..0xA3) in cycle 10, then sel_valid=0. Required: active data on the outputs from cycle 12 and held thereafter, out_src=2, sw_pulse high only in cycle 12, switch_cnt=1.
- sel=3 (illegal, NUM_SRC=3) with sel_valid=1 while active is selected. Required: output returns to source 0 after PIPE cycles, sel_err=1 and held until err_clr; err_clr and a new illegal sel in the same cycle leave sel_err=1.
- Toggle sel between 1 and 2 every cycle for 10 cycles. Required: each output cycle matches its sampled source, and sw_pulse is high for 10 consecutive cycles.
- Preload switch_cnt to 16'hFFFF via 65535 switches, then switch again. Required: switch_cnt stays 16'hFFFF. Then assert cnt_clr together with a sw_pulse: switch_cnt=0.
- Assert rst_n low mid-stream while source 2 is in the pipeline. Required: all outputs read their reset values immediately, without waiting for a clock edge, and no sw_pulse occurs after release.
